// File: rtl/ct_f_spsram_pkg.sv
// Shared sizing, FSM encoding and write-enable helper for the 64x108 single-port SRAM controller.
package ct_f_spsram_pkg;

   localparam int ADDR_WIDTH = 6;
   localparam int BANK_WIDTH = 27;
   localparam int NBANK      = 4;
   localparam int DATA_WIDTH = NBANK * BANK_WIDTH;
   localparam int RSP_DEPTH  = 2;

   typedef enum logic [1:0] {
      RST_WAIT = 2'd0,
      INIT     = 2'd1,
      RUN      = 2'd2
   } ctrl_state_e;

   // Replicates each bank enable across its BANK_WIDTH bits (active-high).
   function automatic logic [DATA_WIDTH-1:0] expand_be(input logic [NBANK-1:0] be);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NBANK; i++) begin
         r[i*BANK_WIDTH +: BANK_WIDTH] = {BANK_WIDTH{be[i]}};
      end
      return r;
   endfunction

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry shift-style response FIFO; entry 0 is always the head.
module ct_f_spsram_rsp_fifo
   import ct_f_spsram_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            count,
   output logic                  full,
   output logic                  empty
);

   logic [DATA_WIDTH-1:0] ent0;
   logic [DATA_WIDTH-1:0] ent1;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = ent0;

   // Popping the last entry leaves ent0 untouched, so dout holds the last value while empty.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= 2'd0;
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= din;
               else               ent1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) ent0 <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ct_f_spsram_64x108_ctrl.sv
// Request-side controller for the 64x108 single-port SRAM: zero-fill after reset, then
// one read or write per cycle with in-order read data through a 2-entry response buffer.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RST_WAIT | reset just released, SRAM idle
//   INIT     | writing zero to address init_cnt, one word per cycle
//   RUN      | serving requests; terminal until next RST
module ct_f_spsram_64x108_ctrl
   import ct_f_spsram_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   output logic                  init_done,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [NBANK-1:0]      req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] Q
);

   localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;

   ctrl_state_e           state;
   ctrl_state_e           state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  inflight;
   logic                  acc;
   logic                  rsp_pop;
   logic [1:0]            rsp_cnt;
   logic                  rsp_empty;
   logic                  rsp_full_unused;
   logic [2:0]            credit_used;

   assign acc       = req_valid && req_ready;
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign rsp_valid = !rsp_empty;
   assign init_done = (state == RUN);

   // A pop this cycle frees its slot in time for a read accepted now, which keeps
   // back-to-back reads at one per cycle while the consumer is draining.
   assign credit_used = {1'b0, rsp_cnt} + {2'b0, inflight} - {2'b0, rsp_pop};
   assign req_ready   = (state == RUN) && (req_wr || (credit_used < 3'(RSP_DEPTH)));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= RST_WAIT;
         init_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= acc && !req_wr;
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      CEN       = 1'b1;
      GWEN      = 1'b1;
      WEN       = '1;
      A         = '0;
      D         = '0;
      case (state)
         RST_WAIT: state_nxt = INIT;
         INIT: begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = init_cnt;
            if (init_cnt == INIT_LAST) state_nxt = RUN;
         end
         RUN: begin
            CEN  = !acc;
            GWEN = !(acc && req_wr);
            A    = req_addr;
            D    = req_wdata;
            WEN  = req_wr ? ~expand_be(req_be) : '1;
         end
         default: state_nxt = RST_WAIT;
      endcase
   end

   ct_f_spsram_rsp_fifo u_rsp_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (inflight),
      .pop   (rsp_pop),
      .din   (Q),
      .dout  (rsp_rdata),
      .count (rsp_cnt),
      .full  (rsp_full_unused),
      .empty (rsp_empty)
   );

endmodule

// File: tb/tb_ct_f_spsram_64x108_ctrl.sv
// Directed bench for ct_f_spsram_64x108_ctrl with a behavioural 64x108 SRAM in place of the macro.
module tb_ct_f_spsram_64x108_ctrl;

   logic         CLK = 1'b0;
   logic         RST;
   logic         init_done;
   logic         req_valid;
   logic         req_ready;
   logic         req_wr;
   logic [5:0]   req_addr;
   logic [107:0] req_wdata;
   logic [3:0]   req_be;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [107:0] rsp_rdata;
   logic [5:0]   A;
   logic         CEN;
   logic         GWEN;
   logic [107:0] WEN;
   logic [107:0] D;
   logic [107:0] Q;

   logic [107:0] mem [64];

   int n_cmp = 0;
   int n_mis = 0;
   int n_wait;
   int ready_bad;

   localparam logic [107:0] PAT_A5 = 108'hA5A5A5A5A5A5A5A5A5A5A5A5A5A;
   localparam logic [107:0] ONES   = {108{1'b1}};
   localparam logic [107:0] PAT_B9 = {{27{1'b1}}, 27'd0, {27{1'b1}}, 27'd0};

   always #5 CLK = ~CLK;

   ct_f_spsram_64x108_ctrl dut (
      .CLK       (CLK),
      .RST       (RST),
      .init_done (init_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .A         (A),
      .CEN       (CEN),
      .GWEN      (GWEN),
      .WEN       (WEN),
      .D         (D),
      .Q         (Q)
   );

   // SRAM model: synchronous, bit-masked write, registered Q on any access.
   always @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         Q <= mem[A];
      end
   end

   function automatic logic [107:0] pat(input logic [5:0] a);
      return {21'h1ABCD, a, 21'h0F0F0, a, 21'h15555, a, 21'h0A0A0, a};
   endfunction

   task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic wr, input logic [5:0] a,
                        input logic [107:0] wd, input logic [3:0] be);
      req_valid = v;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = wd;
      req_be    = be;
   endtask

   task automatic rst_vals(input string tag);
      chk({tag, "_init_done"}, 108'(init_done), 108'd0);
      chk({tag, "_req_ready"}, 108'(req_ready), 108'd0);
      chk({tag, "_rsp_valid"}, 108'(rsp_valid), 108'd0);
      chk({tag, "_CEN"},  108'(CEN),  108'd1);
      chk({tag, "_GWEN"}, 108'(GWEN), 108'd1);
      chk({tag, "_WEN"},  WEN, ONES);
      chk({tag, "_A"},    108'(A), 108'd0);
      chk({tag, "_D"},    D, 108'd0);
   endtask

   task automatic stream_read(input bit use_pat);
      for (int c = 0; c < 66; c++) begin
         drive(c < 64, 1'b0, 6'(c), '0, 4'h0);
         rsp_ready = 1'b1;
         @(negedge CLK);
         if (c < 64) chk("stream_ready", 108'(req_ready), 108'd1);
         if (c >= 2) begin
            chk("stream_valid", 108'(rsp_valid), 108'd1);
            chk("stream_data", rsp_rdata, use_pat ? pat(6'(c - 2)) : 108'd0);
         end
         step();
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_init(input int limit);
      n_wait    = -1;
      ready_bad = 0;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (init_done) begin
            n_wait = i;
            break;
         end
         if (req_ready) ready_bad++;
      end
   endtask

   initial begin
      RST       = 1'b1;
      rsp_ready = 1'b1;
      drive(1'b1, 1'b1, 6'd3, ONES, 4'hF);
      repeat (3) step();
      rst_vals("reset");

      // zero-fill: a write held at the port must not be taken during INIT
      RST = 1'b0;
      wait_init(200);
      chk("init_latency", 108'(n_wait), 108'd65);
      chk("init_ready_low", 108'(ready_bad), 108'd0);
      req_valid = 1'b0;
      stream_read(1'b0);

      // write then read same address
      drive(1'b1, 1'b1, 6'd5, PAT_A5, 4'hF);
      @(negedge CLK); chk("t2_wr_ready", 108'(req_ready), 108'd1);
      step();
      drive(1'b1, 1'b0, 6'd5, '0, 4'h0);
      @(negedge CLK); chk("t2_rd_ready", 108'(req_ready), 108'd1);
      step();
      req_valid = 1'b0;
      @(negedge CLK); chk("t2_valid_t1", 108'(rsp_valid), 108'd0);
      step();
      @(negedge CLK);
      chk("t2_valid_t2", 108'(rsp_valid), 108'd1);
      chk("t2_data", rsp_rdata, PAT_A5);
      step();

      // partial bank write
      drive(1'b1, 1'b1, 6'd9, ONES, 4'hF);
      step();
      drive(1'b1, 1'b1, 6'd9, '0, 4'b0101);
      step();
      drive(1'b1, 1'b0, 6'd9, '0, 4'h0);
      step();
      req_valid = 1'b0;
      step();
      @(negedge CLK);
      chk("t3_valid", 108'(rsp_valid), 108'd1);
      chk("t3_data", rsp_rdata, PAT_B9);
      step();

      // backpressure: two reads fill the buffer, third stalls, writes still go
      rsp_ready = 1'b0;
      drive(1'b1, 1'b0, 6'd5, '0, 4'h0);
      @(negedge CLK); chk("t4_rd0_ready", 108'(req_ready), 108'd1);
      step();
      drive(1'b1, 1'b0, 6'd9, '0, 4'h0);
      @(negedge CLK); chk("t4_rd1_ready", 108'(req_ready), 108'd1);
      step();
      drive(1'b1, 1'b0, 6'd0, '0, 4'h0);
      @(negedge CLK); chk("t4_rd2_stall", 108'(req_ready), 108'd0);
      step();
      drive(1'b1, 1'b1, 6'd20, PAT_A5, 4'hF);
      @(negedge CLK);
      chk("t4_wr_full_ready", 108'(req_ready), 108'd1);
      chk("t4_full_valid", 108'(rsp_valid), 108'd1);
      step();
      drive(1'b1, 1'b0, 6'd0, '0, 4'h0);
      @(negedge CLK);
      chk("t4_rd2_still_stall", 108'(req_ready), 108'd0);
      chk("t4_head_held", rsp_rdata, PAT_A5);
      step();
      rsp_ready = 1'b1;
      @(negedge CLK);
      chk("t4_rd2_accept", 108'(req_ready), 108'd1);
      chk("t4_drain0", rsp_rdata, PAT_A5);
      step();
      req_valid = 1'b0;
      @(negedge CLK);
      chk("t4_drain1_valid", 108'(rsp_valid), 108'd1);
      chk("t4_drain1", rsp_rdata, PAT_B9);
      step();
      @(negedge CLK);
      chk("t4_drain2_valid", 108'(rsp_valid), 108'd1);
      chk("t4_drain2", rsp_rdata, 108'd0);
      step();
      @(negedge CLK);
      chk("t4_empty", 108'(rsp_valid), 108'd0);

      // fill every word with a distinct pattern, then stream it back
      step();
      for (int a = 0; a < 64; a++) begin
         drive(1'b1, 1'b1, 6'(a), pat(6'(a)), 4'hF);
         @(negedge CLK); chk("t5_wr_ready", 108'(req_ready), 108'd1);
         step();
      end
      stream_read(1'b1);

      // reset with the buffer full and a read stalled at the port
      rsp_ready = 1'b0;
      drive(1'b1, 1'b0, 6'd5, '0, 4'h0);
      step();
      drive(1'b1, 1'b0, 6'd9, '0, 4'h0);
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("t6_pre_valid", 108'(rsp_valid), 108'd1);
      drive(1'b1, 1'b0, 6'd7, ONES, 4'hF);
      RST = 1'b1;
      #1;
      rst_vals("t6_rst_run");
      step();
      RST = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (31) step();
      chk("t6_fill_addr30", 108'(A), 108'd30);
      chk("t6_fill_cen", 108'(CEN), 108'd0);
      RST = 1'b1;
      #1;
      rst_vals("t6_rst_init");
      step();
      RST = 1'b0;
      step();
      chk("t6_restart_addr", 108'(A), 108'd0);
      chk("t6_restart_cen", 108'(CEN), 108'd0);
      chk("t6_restart_gwen", 108'(GWEN), 108'd0);
      chk("t6_restart_wen", WEN, 108'd0);
      wait_init(200);
      chk("t6_refill_len", 108'(n_wait), 108'd64);
      chk("t6_after_valid", 108'(rsp_valid), 108'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
